// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU operand/op selects and trap causes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd2;

  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_IALU) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs, enables,
// selects and retirement/trap status.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op,
           state, retire, instret, trap, trap_cause
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           mem_to_reg, pc_src, alu_src_a, alu_src_b, alu_op,
           state, retire, instret, trap, trap_cause
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access has waited; expired flags the last
// cycle in which mem_ready may still arrive before a timeout.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count && (cnt_q != W'(LIMIT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback with
// memory-wait timeout, illegal-opcode trap and retired-instruction count.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t      state_q, state_d;
  logic [6:0]  opc_q, opc_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic        wait_clear, wait_count, wait_expired;

  logic       pc_write, ir_write, mem_read, mem_write, iord;
  logic       reg_write, mem_to_reg, pc_src, retire;
  logic [1:0] alu_src_a, alu_src_b, alu_op;

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    wait_count = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    retire     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;

    case (state_q)
      ST_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        wait_count = !bus.mem_ready;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        opc_d     = bus.opcode;
        if (opc_legal(bus.opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        alu_src_a = SRCA_RS1;
        case (opc_q)
          OPC_RTYPE: begin
            alu_op  = ALU_FUNCT;
            state_d = ST_WB;
          end
          OPC_IALU: begin
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
            state_d   = ST_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b = SRCB_IMM;
            state_d   = ST_MEM;
          end
          OPC_BRANCH: begin
            alu_op   = ALU_SUB;
            pc_src   = 1'b1;
            pc_write = bus.zero;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          default: begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        iord       = 1'b1;
        mem_read   = (opc_q == OPC_LOAD);
        mem_write  = (opc_q != OPC_LOAD);
        wait_count = !bus.mem_ready;
        if (bus.mem_ready) begin
          if (opc_q == OPC_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opc_q == OPC_LOAD);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Held reset must silence the datapath even though state sits at FETCH.
    if (!reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      retire     = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
    end

    instret_d = instret_q + {31'd0, retire};
  end

  assign wait_clear = (state_d != state_q) &&
                      ((state_d == ST_FETCH) || (state_d == ST_MEM));

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .count   (wait_count),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_ff @(posedge clk) opc_q <= opc_d;

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.iord       = iord;
  assign bus.reg_write  = reg_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.retire     = retire;
  assign bus.state      = state_q;
  assign bus.instret    = instret_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/control vectors
// checked against hand-written expectations.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pw, ir, mr, mw, iord, rw, mtr, ps, src_a, src_b, alu_op, retire}
  localparam logic [17:0] V_ZERO   = 18'b000_00000000_00_00_00_0;
  localparam logic [17:0] V_F_RDY  = 18'b000_11100000_00_01_00_0;
  localparam logic [17:0] V_F_WAIT = 18'b000_00100000_00_01_00_0;
  localparam logic [17:0] V_DEC    = 18'b001_00000000_01_10_00_0;
  localparam logic [17:0] V_EX_R   = 18'b010_00000000_10_00_10_0;
  localparam logic [17:0] V_EX_I   = 18'b010_00000000_10_10_10_0;
  localparam logic [17:0] V_EX_LS  = 18'b010_00000000_10_10_00_0;
  localparam logic [17:0] V_EX_BZ  = 18'b010_10000001_10_00_01_1;
  localparam logic [17:0] V_EX_BN  = 18'b010_00000001_10_00_01_1;
  localparam logic [17:0] V_MEM_LD = 18'b011_00101000_00_00_00_0;
  localparam logic [17:0] V_MEM_ST = 18'b011_00011000_00_00_00_0;
  localparam logic [17:0] V_MEM_SR = 18'b011_00011000_00_00_00_1;
  localparam logic [17:0] V_WB_R   = 18'b100_00000100_00_00_00_1;
  localparam logic [17:0] V_WB_L   = 18'b100_00000110_00_00_00_1;
  localparam logic [17:0] V_TRAP   = 18'b111_00000000_00_00_00_0;

  function automatic logic [17:0] obs();
    return {bus.state, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
            bus.iord, bus.reg_write, bus.mem_to_reg, bus.pc_src,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.retire};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.opcode    = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.opcode    = 7'b0110011;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== V_ZERO) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", obs(), V_ZERO);
    end
    total++;
    if ({bus.instret, bus.trap, bus.trap_cause} !== 35'd0) begin
      bad++; $display("FAIL reset_status instret=%0d trap=%b cause=%0d exp all 0",
                      bus.instret, bus.trap, bus.trap_cause);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    logic [17:0] exp_v [5];
    exp_v = '{V_F_RDY, V_DEC, V_EX_R, V_WB_R, V_F_RDY};
    do_reset();
    bus.opcode    = 7'b0110011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== exp_v[i]) begin
        bad++; $display("FAIL rtype cyc%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      step();
    end
    total++;
    if (bus.instret !== 32'd1) begin
      bad++; $display("FAIL rtype_instret got=%0d exp=1", bus.instret);
    end
  endtask

  task automatic test_ialu();
    logic [17:0] exp_v [4];
    exp_v = '{V_F_RDY, V_DEC, V_EX_I, V_WB_R};
    do_reset();
    bus.opcode    = 7'b0010011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== exp_v[i]) begin
        bad++; $display("FAIL ialu cyc%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      step();
    end
  endtask

  task automatic test_load_wait();
    logic [17:0] exp_v [12];
    logic        rdy   [12];
    exp_v = '{V_F_WAIT, V_F_WAIT, V_F_WAIT, V_F_RDY, V_DEC, V_EX_LS,
              V_MEM_LD, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB_L, V_F_WAIT};
    rdy   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus.opcode = 7'b0000011;
    for (int i = 0; i < 12; i++) begin
      bus.mem_ready = rdy[i];
      @(negedge clk);
      total++;
      if (obs() !== exp_v[i]) begin
        bad++; $display("FAIL load cyc%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      step();
    end
    total++;
    if (bus.instret !== 32'd1) begin
      bad++; $display("FAIL load_instret got=%0d exp=1", bus.instret);
    end
  endtask

  task automatic test_back_to_back_branch();
    logic [17:0] exp_v [7];
    logic        zf    [7];
    exp_v = '{V_F_RDY, V_DEC, V_EX_BZ, V_F_RDY, V_DEC, V_EX_BN, V_F_RDY};
    zf    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    bus.opcode    = 7'b1100011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.zero = zf[i];
      @(negedge clk);
      total++;
      if (obs() !== exp_v[i]) begin
        bad++; $display("FAIL branch cyc%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      step();
    end
    total++;
    if (bus.instret !== 32'd2) begin
      bad++; $display("FAIL branch_instret got=%0d exp=2", bus.instret);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.opcode    = 7'h7F;
    bus.mem_ready = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (obs() !== V_DEC || bus.trap !== 1'b0) begin
      bad++; $display("FAIL illegal_decode got=%b trap=%b exp=%b trap=0", obs(), bus.trap, V_DEC);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      bus.zero = i[0];
      @(negedge clk);
      total++;
      if (obs() !== V_TRAP || bus.trap !== 1'b1 || bus.trap_cause !== 2'd1) begin
        bad++; $display("FAIL illegal_trap cyc%0d got=%b trap=%b cause=%0d exp=%b trap=1 cause=1",
                        i, obs(), bus.trap, bus.trap_cause, V_TRAP);
      end
    end
    do_reset();
    @(negedge clk);
    total++;
    if (bus.trap !== 1'b0 || bus.trap_cause !== 2'd0 || bus.state !== 3'd0) begin
      bad++; $display("FAIL illegal_clear trap=%b cause=%0d state=%0d exp 0/0/0",
                      bus.trap, bus.trap_cause, bus.state);
    end
  endtask

  task automatic test_store_timeout();
    int n;
    n = 0;
    do_reset();
    bus.opcode    = 7'b0100011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.state != 3'd3) break;
      if (bus.mem_write === 1'b1) n++;
      step();
    end
    total++;
    if (n != 16) begin
      bad++; $display("FAIL store_timeout_len got=%0d exp=16", n);
    end
    total++;
    if (obs() !== V_TRAP || bus.trap !== 1'b1 || bus.trap_cause !== 2'd2) begin
      bad++; $display("FAIL store_timeout_trap got=%b trap=%b cause=%0d exp=%b trap=1 cause=2",
                      obs(), bus.trap, bus.trap_cause, V_TRAP);
    end
  endtask

  task automatic test_store_at_limit();
    do_reset();
    bus.opcode    = 7'b0100011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 16; i++) begin
      bus.mem_ready = (i == 15);
      @(negedge clk);
      if (i == 0 || i >= 14) begin
        total++;
        if (obs() !== ((i == 15) ? V_MEM_SR : V_MEM_ST)) begin
          bad++; $display("FAIL store_limit cyc%0d got=%b exp=%b", i, obs(),
                          (i == 15) ? V_MEM_SR : V_MEM_ST);
        end
      end
      step();
    end
    @(negedge clk);
    total++;
    if (bus.state !== 3'd0 || bus.trap !== 1'b0 || bus.instret !== 32'd1) begin
      bad++; $display("FAIL store_limit_after state=%0d trap=%b instret=%0d exp 0/0/1",
                      bus.state, bus.trap, bus.instret);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    bus.opcode    = 7'b0110011;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.opcode = 7'b0100011;
    for (int i = 0; i < 3; i++) step();
    bus.mem_ready = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (obs() !== V_MEM_ST || bus.instret !== 32'd1) begin
      bad++; $display("FAIL midreset_pre got=%b instret=%0d exp=%b instret=1",
                      obs(), bus.instret, V_MEM_ST);
    end
    step();
    reset = 1'b0;
    #1;
    total++;
    if (obs() !== V_ZERO || bus.instret !== 32'd0) begin
      bad++; $display("FAIL midreset_now got=%b instret=%0d exp=%b instret=0",
                      obs(), bus.instret, V_ZERO);
    end
    bus.mem_ready = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (obs() !== V_ZERO) begin
      bad++; $display("FAIL midreset_held got=%b exp=%b", obs(), V_ZERO);
    end
    reset = 1'b1;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.opcode    = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    test_reset();
    test_rtype();
    test_ialu();
    test_load_wait();
    test_back_to_back_branch();
    test_illegal();
    test_store_timeout();
    test_store_at_limit();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles to wait for mem_ready in one access.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  instruction[6:0] from the datapath instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  unified memory access complete this cycle.
REQ-007 SHALL have outputs pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, pc_src  output  1 each  datapath enables/selects (iord: 0=PC address, 1=ALUOut address; pc_src: 0=ALU result, 1=ALUOut).
REQ-008 SHALL have outputs alu_src_a  output  2  (0=PC, 1=old PC, 2=rs1); alu_src_b  output  2  (0=rs2, 1=const 4, 2=imm); alu_op  output  2  (00=add, 01=sub/compare, 10=funct-decoded).
REQ-009 SHALL have outputs state  output  3  current state; retire  output  1  one-cycle pulse per completed instruction; instret  output  32  retired-instruction count; trap  output  1  sticky fault; trap_cause  output  2  (0=none, 1=illegal opcode, 2=memory timeout).

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-011 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00; hold until mem_ready; in the mem_ready cycle ir_write=1, pc_write=1, pc_src=0; next DECODE.
REQ-012 DECODE: alu_src_a=1, alu_src_b=2, alu_op=00 (branch target into ALUOut); latch opcode internally; next EXEC if opcode in {0110011, 0010011, 0000011, 0100011, 1100011}, else TRAP cause 1.
REQ-013 EXEC R-type: alu_src_a=2, alu_src_b=0, alu_op=10, next WB; I-ALU: alu_src_b=2, otherwise same.
REQ-014 EXEC load/store: alu_src_a=2, alu_src_b=2, alu_op=00, next MEM.
REQ-015 EXEC branch: alu_src_a=2, alu_src_b=0, alu_op=01, pc_src=1, pc_write=zero (combinational), retire=1, next FETCH.
REQ-016 MEM: iord=1; load asserts mem_read, store asserts mem_write, held until mem_ready; load then WB; store then FETCH with retire=1 in the mem_ready cycle.
REQ-017 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 only for load, retire=1; next FETCH.
REQ-018 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle mem_ready=0; reaching MEM_TIMEOUT without mem_ready SHALL go to TRAP cause 2; mem_ready in the same cycle as the limit wins (no trap).
REQ-019 TRAP: all enables 0, trap=1, trap_cause held; exit only via reset.
REQ-020 instret SHALL increment on every retire, wrapping 0xFFFFFFFF -> 0.
REQ-021 All enables not listed for a state SHALL be 0; unlisted selects SHALL be 0.

Reset
REQ-022 reset low SHALL asynchronously force state=FETCH, instret=0, trap=0, trap_cause=0, wait counter=0.
REQ-023 While reset low all control outputs and retire SHALL be 0; fetch begins on first clk edge after release.
REQ-024 Reset mid-access SHALL abandon the access with no pc_write, reg_write or mem_write after assertion.

Structure
REQ-025 Package multicycle_pkg SHALL hold state encodings, opcode constants, alu_op and alu_src encodings, trap_cause codes.
REQ-026 Wait counter SHALL be sub-module mem_wait_timer (clear, count, expired), width clog2(MEM_TIMEOUT+1).

Verification
REQ-027 R-type add, mem_ready=1 always -> states 0,1,2,4,0; one reg_write pulse; retire once; instret 0->1.
REQ-028 Load with mem_ready delayed 3 cycles in FETCH and MEM -> mem_read held 4 cycles each, mem_to_reg=1 in WB, 7+ cycles total.
REQ-029 Branch with zero=1 then zero=0 -> pc_write=1 and pc_src=1 in EXEC only when zero=1; both retire.
REQ-030 opcode=0x7F -> DECODE->TRAP, trap=1, trap_cause=1, no further enables until reset.
REQ-031 Store with mem_ready never high, MEM_TIMEOUT=16 -> mem_write held 16 cycles then TRAP cause 2; ready exactly at limit -> no trap.
REQ-032 reset pulsed during MEM of store -> mem_write drops immediately, state=0, instret=0.
